// File: rtl/fpu_pkg.sv
// ----------------------------------------------------------------------------
// fpu_pkg
// Shared types for the FPU request sequencer: opcode and word types, the
// sequencer FSM state encoding, and the packed request entry that is stored
// in the request FIFO (operands plus opcode, 66 bits).
// ----------------------------------------------------------------------------
package fpu_pkg;

  typedef logic [1:0]  fpu_op_t;
  typedef logic [31:0] fpu_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } seq_state_t;

  typedef struct packed {
    fpu_word_t a;
    fpu_word_t b;
    fpu_op_t   op;
  } fpu_req_t;

  localparam int REQ_W = $bits(fpu_req_t);

endpackage

// File: rtl/fpu_req_fifo.sv
// ----------------------------------------------------------------------------
// fpu_req_fifo
// Small synchronous FIFO holding pending FPU requests. No fall-through: a
// push into an empty FIFO becomes visible at o_head only after the edge.
// Pushes while full and pops while empty are ignored internally.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_push       write request (ignored when full)
//   i_data       entry to write
//   i_pop        read request (ignored when empty)
//   o_head       entry at the read pointer
//   o_full       DEPTH entries held
//   o_empty      no entries held
// ----------------------------------------------------------------------------
module fpu_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 66
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd];

  // Pointers are PW bits wide so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; only entries behind the write pointer are read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/fpu_op_sequencer.sv
// ----------------------------------------------------------------------------
// fpu_op_sequencer
// Buffers FPU requests in a FIFO and issues them to the FPU one at a time:
// operands are held for LAT cycles, fpu_outp is captured, and the result is
// offered on a valid/ready handshake. One op in flight, results in order.
//
// Optional feature: define FPU_SEQ_TAG_EN to add req_tag/res_tag; the tag
// travels with its request through the FIFO and returns with the result.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (ready = FIFO not full)
//   req_a, req_b, req_op    operands and opcode
//   req_tag                 request tag (FPU_SEQ_TAG_EN only)
//   fpu_a, fpu_b, fpu_op    registered drive into the FPU
//   fpu_outp                FPU result
//   res_valid/res_ready     result handshake
//   res_data                captured result
//   res_tag                 tag of result (FPU_SEQ_TAG_EN only)
//   busy                    FIFO non-empty or an op in flight
// ----------------------------------------------------------------------------
import fpu_pkg::*;

module fpu_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int LAT   = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [1:0]       req_op,
`ifdef FPU_SEQ_TAG_EN
  input  logic [TAG_W-1:0] req_tag,
`endif
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic [1:0]       fpu_op,
  input  logic [31:0]      fpu_outp,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
`ifdef FPU_SEQ_TAG_EN
  output logic [TAG_W-1:0] res_tag,
`endif
  output logic             busy
);

`ifdef FPU_SEQ_TAG_EN
  localparam int TAG_USED = 1;
`else
  localparam int TAG_USED = 0;
`endif
  localparam int ENTRY_W = REQ_W + TAG_USED * TAG_W;
  localparam int CW      = (LAT > 1) ? $clog2(LAT) : 1;

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic [CW-1:0]    r_cnt;
  fpu_word_t        r_fpu_a;
  fpu_word_t        r_fpu_b;
  fpu_op_t          r_fpu_op;
  fpu_word_t        r_res_data;
  logic             r_res_valid;
  logic [ENTRY_W-1:0] w_push_data;
  logic [ENTRY_W-1:0] w_head;
  fpu_req_t         w_head_req;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_capture;
  logic             w_release;

`ifdef FPU_SEQ_TAG_EN
  logic [TAG_W-1:0] r_res_tag;
  logic [TAG_W-1:0] r_fpu_tag;
  assign w_push_data = {req_tag, req_a, req_b, req_op};
  assign res_tag     = r_res_tag;
`else
  assign w_push_data = {req_a, req_b, req_op};
`endif

  assign w_head_req = w_head[REQ_W-1:0];

  fpu_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (req_valid),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign req_ready = !w_full;
  assign busy      = !w_empty || (r_state != IDLE);
  assign fpu_a     = r_fpu_a;
  assign fpu_b     = r_fpu_b;
  assign fpu_op    = r_fpu_op;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Pop only from IDLE so the operands never change while an op is in flight.
  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_capture = 1'b0;
    w_release = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_capture = 1'b1;
          w_next    = HOLD;
        end
      end
      HOLD: begin
        if (r_res_valid && res_ready) begin
          w_release = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand/tag registers, settle counter and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_fpu_a     <= '0;
      r_fpu_b     <= '0;
      r_fpu_op    <= '0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
`ifdef FPU_SEQ_TAG_EN
      r_fpu_tag   <= '0;
      r_res_tag   <= '0;
`endif
    end else begin
      if (w_pop) begin
        r_fpu_a  <= w_head_req.a;
        r_fpu_b  <= w_head_req.b;
        r_fpu_op <= w_head_req.op;
        r_cnt    <= CW'(LAT - 1);
`ifdef FPU_SEQ_TAG_EN
        r_fpu_tag <= w_head[ENTRY_W-1:REQ_W];
`endif
      end else if (r_state == WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_capture) begin
        r_res_data  <= fpu_outp;
        r_res_valid <= 1'b1;
`ifdef FPU_SEQ_TAG_EN
        r_res_tag   <= r_fpu_tag;
`endif
      end else if (w_release) begin
        r_res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fpu_op_sequencer
// Self-checking bench for fpu_op_sequencer. Two instances: DEPTH=4/LAT=2 with
// a one-cycle-registered FPU stand-in, and DEPTH=4/LAT=1 with a combinational
// stand-in. Expected results come from a queue of requests and an arithmetic
// stand-in for the FPU function. Build with FPU_SEQ_TAG_EN to cover tags.
// ----------------------------------------------------------------------------
module tb_fpu_op_sequencer;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] res;
    logic [3:0]  tag;
  } expT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reqValid, reqReady, resValid, resReady, busy;
  logic [31:0] reqA, reqB, fpuA, fpuB, fpuOutp, resData;
  logic [1:0]  reqOp, fpuOp;
  logic        reqValid1, reqReady1, resValid1, resReady1, busy1;
  logic [31:0] reqA1, reqB1, fpuA1, fpuB1, fpuOutp1, resData1;
  logic [1:0]  reqOp1, fpuOp1;
`ifdef FPU_SEQ_TAG_EN
  logic [3:0]  reqTag, resTag, reqTag1, resTag1;
`endif

  int  nCompared = 0;
  int  nMismatched = 0;
  int  tagCnt = 0;
  expT expQ[$];
  expT q1[$];

  always #5 clk = ~clk;

  // Arbitrary but distinct function per opcode, standing in for the FPU.
  function automatic logic [31:0] refFpu(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] op);
    case (op)
      2'd0:    refFpu = a + b;
      2'd1:    refFpu = a - b;
      2'd2:    refFpu = a * b;
      default: refFpu = a ^ {b[15:0], b[31:16]};
    endcase
  endfunction

  // FPU stand-in for LAT=2: result is valid one edge after the operands.
  always_ff @(posedge clk) fpuOutp <= refFpu(fpuA, fpuB, fpuOp);
  assign fpuOutp1 = refFpu(fpuA1, fpuB1, fpuOp1);

  fpu_op_sequencer #(.DEPTH(4), .LAT(2), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(reqValid), .req_ready(reqReady),
    .req_a(reqA), .req_b(reqB), .req_op(reqOp),
`ifdef FPU_SEQ_TAG_EN
    .req_tag(reqTag),
`endif
    .fpu_a(fpuA), .fpu_b(fpuB), .fpu_op(fpuOp), .fpu_outp(fpuOutp),
    .res_valid(resValid), .res_ready(resReady), .res_data(resData),
`ifdef FPU_SEQ_TAG_EN
    .res_tag(resTag),
`endif
    .busy(busy)
  );

  fpu_op_sequencer #(.DEPTH(4), .LAT(1), .TAG_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(reqValid1), .req_ready(reqReady1),
    .req_a(reqA1), .req_b(reqB1), .req_op(reqOp1),
`ifdef FPU_SEQ_TAG_EN
    .req_tag(reqTag1),
`endif
    .fpu_a(fpuA1), .fpu_b(fpuB1), .fpu_op(fpuOp1), .fpu_outp(fpuOutp1),
    .res_valid(resValid1), .res_ready(resReady1), .res_data(resData1),
`ifdef FPU_SEQ_TAG_EN
    .res_tag(resTag1),
`endif
    .busy(busy1)
  );

  task automatic checkOutput(input string name, input logic [31:0] obs,
                             input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Drive a random request on dut and return its expected entry.
  task automatic driveReq(output expT e);
    e.a   = $urandom | 32'h1;
    e.b   = $urandom;
    e.op  = 2'($urandom_range(0, 3));
    e.tag = 4'(tagCnt);
    e.res = refFpu(e.a, e.b, e.op);
    tagCnt++;
    reqA  = e.a;
    reqB  = e.b;
    reqOp = e.op;
`ifdef FPU_SEQ_TAG_EN
    reqTag = e.tag;
`endif
    reqValid = 1'b1;
  endtask

  // Push nPush requests whenever accepted, drain with random or tied-high
  // res_ready, and check every presented result against the queue head.
  task automatic applyStimulus(input int nPush, input int maxCycles, input bit randReady);
    int  left = nPush;
    int  cyc = 0;
    expT e;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (resValid) begin
        if (expQ.size() == 0) begin
          checkOutput("order.stray", 32'(resValid), 32'd0);
        end else begin
          checkOutput("order.data", resData, expQ[0].res);
`ifdef FPU_SEQ_TAG_EN
          checkOutput("order.tag", 32'(resTag), 32'(expQ[0].tag));
`endif
        end
      end
      if (left == 0 && expQ.size() == 0 && !resValid) break;
      if (cyc >= maxCycles) begin
        nCompared++;
        nMismatched++;
        $error("[TB] FAIL stim.timeout: pending=%0d required=0", expQ.size() + left);
        break;
      end
      resReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (resValid && resReady && expQ.size() > 0) void'(expQ.pop_front());
      if (left > 0 && reqReady) begin
        driveReq(e);
        expQ.push_back(e);
        left--;
      end else begin
        reqValid = 1'b0;
      end
    end
    reqValid = 1'b0;
  endtask

  initial begin
    expT e, e2;
    int  cyc, got, lastCyc, left;
    logic [31:0] held;

    rst_n = 1'b0;
    reqValid = 1'b0; reqA = '0; reqB = '0; reqOp = '0; resReady = 1'b0;
    reqValid1 = 1'b0; reqA1 = '0; reqB1 = '0; reqOp1 = '0; resReady1 = 1'b1;
`ifdef FPU_SEQ_TAG_EN
    reqTag = '0; reqTag1 = '0;
`endif

    // Reset values.
    @(negedge clk); @(negedge clk);
    checkOutput("reset.req_ready", 32'(reqReady), 32'd1);
    checkOutput("reset.res_valid", 32'(resValid), 32'd0);
    checkOutput("reset.res_data", resData, 32'd0);
    checkOutput("reset.fpu_a", fpuA, 32'd0);
    checkOutput("reset.fpu_b", fpuB, 32'd0);
    checkOutput("reset.fpu_op", 32'(fpuOp), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
`ifdef FPU_SEQ_TAG_EN
    checkOutput("reset.res_tag", 32'(resTag), 32'd0);
`endif
    rst_n = 1'b1;

    // Single op: push at edge E, result valid after E+3 for LAT=2.
    $display("[TB] single op");
    resReady = 1'b1;
    @(negedge clk);
    e.a = 32'h3E13798B; e.b = 32'h3EAA79BE; e.op = 2'b10;
    e.res = refFpu(e.a, e.b, e.op);
    reqA = e.a; reqB = e.b; reqOp = e.op; reqValid = 1'b1;
`ifdef FPU_SEQ_TAG_EN
    reqTag = 4'd9;
`endif
    @(negedge clk); reqValid = 1'b0;
    checkOutput("single.valid_e0", 32'(resValid), 32'd0);
    checkOutput("single.busy", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("single.fpu_a", fpuA, e.a);
    checkOutput("single.fpu_b", fpuB, e.b);
    checkOutput("single.fpu_op", 32'(fpuOp), 32'(e.op));
    checkOutput("single.valid_e1", 32'(resValid), 32'd0);
    @(negedge clk);
    checkOutput("single.valid_e2", 32'(resValid), 32'd0);
    @(negedge clk);
    checkOutput("single.valid_e3", 32'(resValid), 32'd1);
    checkOutput("single.data", resData, e.res);
`ifdef FPU_SEQ_TAG_EN
    checkOutput("single.tag", 32'(resTag), 32'd9);
`endif
    @(negedge clk);
    checkOutput("single.valid_e4", 32'(resValid), 32'd0);
    checkOutput("single.busy_end", 32'(busy), 32'd0);

    // Fill: 1 in flight + 4 buffered, then a refused 6th push.
    $display("[TB] fill and back-pressure");
    resReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("fill.ready_before_push", 32'(reqReady), 32'd1);
      driveReq(e2);
      expQ.push_back(e2);
    end
    @(negedge clk);
    checkOutput("fill.ready_full", 32'(reqReady), 32'd0);
    driveReq(e2);
    @(negedge clk);
    reqValid = 1'b0;
    checkOutput("fill.ready_after_refused", 32'(reqReady), 32'd0);

    // Back-pressure: stalled in HOLD for 10 cycles.
    cyc = 0;
    while (!resValid && cyc < 20) begin @(negedge clk); cyc++; end
    checkOutput("bp.valid_reached", 32'(resValid), 32'd1);
    held = resData;
    checkOutput("bp.data_first", held, expQ[0].res);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp.valid", 32'(resValid), 32'd1);
      checkOutput("bp.data", resData, held);
      checkOutput("bp.fpu_a", fpuA, expQ[0].a);
      checkOutput("bp.fpu_b", fpuB, expQ[0].b);
      checkOutput("bp.fpu_op", 32'(fpuOp), 32'(expQ[0].op));
      checkOutput("bp.no_pop", 32'(reqReady), 32'd0);
    end

    // Drain the fill, then the ordering run with tags 0..5.
    applyStimulus(0, 200, 1'b1);
    tagCnt = 0;
    $display("[TB] ordering with random res_ready");
    applyStimulus(6, 300, 1'b1);
    applyStimulus(40, 2000, 1'b1);
    resReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("drain.no_stray", 32'(resValid), 32'd0);
    end
    checkOutput("drain.busy", 32'(busy), 32'd0);

    // Reset while in WAIT with cnt=1 and two requests queued.
    $display("[TB] reset mid-WAIT");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      driveReq(e2);
      if (i == 1) e = e2;
    end
    @(negedge clk); reqValid = 1'b0;
    cyc = 0;
    while (!resValid && cyc < 20) begin @(negedge clk); cyc++; end
    checkOutput("rst.hold_reached", 32'(resValid), 32'd1);
    resReady = 1'b1;
    @(negedge clk); resReady = 1'b0;
    @(negedge clk);
    checkOutput("rst.pre_fpu_a", fpuA, e.a);
    checkOutput("rst.pre_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst.async_res_valid", 32'(resValid), 32'd0);
    checkOutput("rst.async_res_data", resData, 32'd0);
    checkOutput("rst.async_fpu_a", fpuA, 32'd0);
    checkOutput("rst.async_fpu_b", fpuB, 32'd0);
    checkOutput("rst.async_fpu_op", 32'(fpuOp), 32'd0);
    checkOutput("rst.async_busy", 32'(busy), 32'd0);
    checkOutput("rst.async_req_ready", 32'(reqReady), 32'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    resReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("rst.no_stale", 32'(resValid), 32'd0);
    end
    checkOutput("rst.busy_after", 32'(busy), 32'd0);

    // LAT=1: continuous pushes, one result every 3 cycles across wrap.
    $display("[TB] LAT=1 streaming");
    left = 10; got = 0; cyc = 0; lastCyc = -1;
    while (got < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (resValid1) begin
        if (q1.size() == 0) begin
          checkOutput("lat1.stray", 32'(resValid1), 32'd0);
        end else begin
          checkOutput("lat1.data", resData1, q1[0].res);
`ifdef FPU_SEQ_TAG_EN
          checkOutput("lat1.tag", 32'(resTag1), 32'(q1[0].tag));
`endif
          void'(q1.pop_front());
        end
        if (lastCyc >= 0) checkOutput("lat1.interval", 32'(cyc - lastCyc), 32'd3);
        lastCyc = cyc;
        got++;
      end
      if (left > 0 && reqReady1) begin
        e2.a = $urandom; e2.b = $urandom; e2.op = 2'($urandom_range(0, 3));
        e2.tag = 4'(10 - left);
        e2.res = refFpu(e2.a, e2.b, e2.op);
        reqA1 = e2.a; reqB1 = e2.b; reqOp1 = e2.op; reqValid1 = 1'b1;
`ifdef FPU_SEQ_TAG_EN
        reqTag1 = e2.tag;
`endif
        q1.push_back(e2);
        left--;
      end else begin
        reqValid1 = 1'b0;
      end
    end
    reqValid1 = 1'b0;
    checkOutput("lat1.count", 32'(got), 32'd10);
    repeat (4) @(negedge clk);
    checkOutput("lat1.no_extra", 32'(resValid1), 32'd0);
    checkOutput("lat1.busy", 32'(busy1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/fpu_op_sequencer.md
# fpu_op_sequencer

Request-side sequencer that sits directly upstream of `fpu` and feeds its `A`, `B` and `opcode` inputs. It buffers operation requests in a small FIFO and issues them one at a time. It then holds the operands stable for the FPU's settle latency, captures `outp` and returns the result through a valid/ready handshake. This lets the FPU be driven from a streaming source instead of from fixed-delay stimulus.

## Interface
Parameters:
- `DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `LAT`, 2: clock cycles from operand drive until `fpu_outp` is valid; ≥1.
- `TAG_W`, 4: tag width; used only when `FPU_SEQ_TAG_EN` is defined.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: FIFO can accept.
- `req_a` in 32: operand A, IEEE-754 single.
- `req_b` in 32: operand B.
- `req_op` in 2: FPU opcode.
- `req_tag` in TAG_W: request tag (`FPU_SEQ_TAG_EN` only).
- `fpu_a` out 32: to `fpu.A`.
- `fpu_b` out 32: to `fpu.B`.
- `fpu_op` out 2: to `fpu.opcode`.
- `fpu_outp` in 32: from `fpu.outp`.
- `res_valid` out 1: result held.
- `res_ready` in 1: consumer accepts.
- `res_data` out 32: captured result.
- `res_tag` out TAG_W: tag of result (`FPU_SEQ_TAG_EN` only).
- `busy` out 1: high when the FIFO is non-empty or state ≠ IDLE.

## Operation
- FIFO:
  - Push when `req_valid && req_ready`.
  - `req_ready = !full`, combinational from the count.
  - Pointers are log2(DEPTH) bits, wrap modulo DEPTH; occupancy count is log2(DEPTH)+1 bits.
  - Simultaneous push and pop when full: the pop happens and the push is refused, because `req_ready` was 0. When empty, a push lands and the pop does not occur that cycle; there is no fall-through.
- FSM states IDLE, WAIT, HOLD:
  - IDLE: if the FIFO is non-empty, pop the head into the `fpu_a/fpu_b/fpu_op` registers (and the tag register), load `cnt = LAT-1`, go to WAIT. Otherwise stay.
  - WAIT: if `cnt == 0`, capture `fpu_outp` into `res_data`, set `res_valid`, go to HOLD. Otherwise decrement `cnt`.
  - HOLD: when `res_valid && res_ready`, clear `res_valid` and go to IDLE.
- Operand registers:
  - Change only on the IDLE pop.
  - Stable through WAIT and HOLD.
- `res_data` and `res_tag` are stable while `res_valid=1`.
- Results are returned in request order; there is one op in flight.

## Timing
- Reset values:
  - Outputs: `req_ready=1`, `res_valid=0`, `res_data=0`, `res_tag=0`, `fpu_a=0`, `fpu_b=0`, `fpu_op=0`, `busy=0`.
  - Internal: FIFO empty, state IDLE, `cnt=0`.
- Latency from push (edge E) to `res_valid`:
  - Pop at E+1, `fpu_*` valid after E+1.
  - Capture at E+1+LAT.
  - `res_valid` high after E+1+LAT.
- Issue interval with `res_ready` tied high is LAT+2 cycles per op.
- `res_ready` high before `res_valid` is ignored. `res_valid` never drops without a handshake.
- Reset mid-operation: the FIFO is flushed, the in-flight op is lost and `res_valid` deasserts immediately, because reset is asynchronous.

## Configuration
- `FPU_SEQ_TAG_EN` defined:
  - `req_tag`/`res_tag` ports exist.
  - FIFO entries are 66+TAG_W bits.
  - `res_tag` returns the tag pushed with the matching request.
- Not defined:
  - The tag ports and tag storage are absent.
  - FIFO entries are 66 bits.
  - All other behaviour is identical.

## Structure
- Package `fpu_pkg`:
  - `fpu_op_t` (2-bit opcode).
  - `fpu_word_t` (32-bit).
  - FSM state enum `seq_state_t` {IDLE, WAIT, HOLD}.
  - Request entry struct.
- One sub-module, `fpu_req_fifo`, parameterised by `DEPTH` and entry width; it provides the full/empty flags.
- The FSM, counter and result register live in the top level.

## Test plan
- Single op:
  - Stimulus: push A=0x3E13798B, B=0x3EAA79BE, op=2'b10 into the real `fpu`, with LAT=2 and `res_ready=1`.
  - Response: `res_valid` rises 3 cycles after the push; `res_data` is within 1 ulp of 0x3EDD75CD.
- Fill FIFO:
  - Stimulus: with `res_ready=0`, push 5 requests, DEPTH=4.
  - Response: `req_ready` drops after the 5th push (1 in flight + 4 buffered); the 6th push is refused.
- Ordering:
  - Stimulus: push 6 vectors back-to-back and toggle `res_ready` randomly.
  - Response: results emerge in push order, each stable while stalled. With the tag enabled, `res_tag` = 0..5 in sequence.
- Back-pressure:
  - Stimulus: hold `res_ready=0` for 10 cycles in HOLD.
  - Response: `res_data`, `fpu_a`, `fpu_b`, `fpu_op` unchanged; no pop occurs.
- Reset mid-WAIT:
  - Stimulus: assert `rst_n=0` while `cnt=1` with 2 requests queued.
  - Response: all outputs go to their reset values asynchronously; after release, `busy=0` and no stale result appears.
- LAT=1 corner:
  - Stimulus: continuous pushes with `res_ready=1`.
  - Response: one result every 3 cycles; no drops or duplicates across pointer wrap.
